id_ex_operand_stage: RTL

//  ID/EX pipeline register plus operand-forwarding front end of the execute stage.

---
 rtl/id_ex_operand_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// Module  : id_ex_operand_stage
// Brief   : ID/EX register with EX/MEM and MEM/WB forwarding and load-use stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic [RAW-1:0]  id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic            id_src_a,
  input  logic            id_src_b,
  input  logic [2:0]      id_ctrl,
  input  logic            flush,
  input  logic            hold,
  input  logic [RAW-1:0]  exm_rd,
  input  logic            exm_we,
  input  logic [XLEN-1:0] exm_res,
  input  logic [RAW-1:0]  wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_res,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      Op,
  output logic            ex_valid,
  output logic [RAW-1:0]  ex_rd,
  output logic [2:0]      ex_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);

  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 0;

  logic            st_valid;
  logic [XLEN-1:0] st_pc;
  logic [XLEN-1:0] st_rs1_data;
  logic [XLEN-1:0] st_rs2_data;
  logic [XLEN-1:0] st_imm;
  logic [RAW-1:0]  st_rs1;
  logic [RAW-1:0]  st_rs2;
  logic [RAW-1:0]  st_rd;
  logic [3:0]      st_op;
  logic            st_src_a;
  logic            st_src_b;
  logic [2:0]      st_ctrl;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            bubble;

  always_comb begin
    load_use_stall = 1'b0;
    if (st_valid && st_ctrl[CTRL_MEM_READ] && (st_rd != '0) && id_valid) begin
      load_use_stall = (st_rd == id_rs1) ||
                       ((st_rd == id_rs2) && !id_src_b) ||
                       ((st_rd == id_rs2) && id_ctrl[CTRL_MEM_WRITE]);
    end
  end

  assign bubble = flush || load_use_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid    <= 1'b0;
      st_pc       <= '0;
      st_rs1_data <= '0;
      st_rs2_data <= '0;
      st_imm      <= '0;
      st_rs1      <= '0;
      st_rs2      <= '0;
      st_rd       <= '0;
      st_op       <= 4'b0000;
      st_src_a    <= 1'b0;
      st_src_b    <= 1'b0;
      st_ctrl     <= 3'b000;
    end else if (hold) begin
      // Whole stage frozen; a concurrent flush is dropped and must be re-issued.
    end else if (bubble) begin
      st_valid <= 1'b0;
      st_ctrl  <= 3'b000;
      st_op    <= 4'b0000;
      st_rd    <= '0;
    end else begin
      st_valid    <= id_valid;
      st_pc       <= id_pc;
      st_rs1_data <= id_rs1_data;
      st_rs2_data <= id_rs2_data;
      st_imm      <= id_imm;
      st_rs1      <= id_rs1;
      st_rs2      <= id_rs2;
      st_rd       <= id_rd;
      st_op       <= id_alu_op;
      st_src_a    <= id_src_a;
      st_src_b    <= id_src_b;
      st_ctrl     <= id_ctrl;
    end
  end

  // EX/MEM has priority over MEM/WB as it holds the younger result; x0 never forwards.
  always_comb begin
    fwd_rs1 = st_rs1_data;
    if (exm_we && (exm_rd != '0) && (exm_rd == st_rs1))
      fwd_rs1 = exm_res;
    else if (wb_we && (wb_rd != '0) && (wb_rd == st_rs1))
      fwd_rs1 = wb_res;
  end

  always_comb begin
    fwd_rs2 = st_rs2_data;
    if (exm_we && (exm_rd != '0) && (exm_rd == st_rs2))
      fwd_rs2 = exm_res;
    else if (wb_we && (wb_rd != '0) && (wb_rd == st_rs2))
      fwd_rs2 = wb_res;
  end

  assign A             = st_src_a ? st_pc  : fwd_rs1;
  assign B             = st_src_b ? st_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Op            = st_op;
  assign ex_valid      = st_valid;
  assign ex_rd         = st_rd;
  assign ex_ctrl       = st_ctrl & {3{st_valid}};

endmodule

`default_nettype wire
